// File: rtl/fsc_4bit_if.sv
// Operand/result bundle for one 4-bit subtractor slice.
// FSC4_FLAGS_EN adds the zero_q/ovf_q flag signals.
interface fsc_4bit_if;
   logic [3:0] a;
   logic [3:0] b;
   logic       bin;
   logic [3:0] diff;
   logic       bout;
   logic [3:0] diff_q;
   logic       bout_q;
`ifdef FSC4_FLAGS_EN
   logic       zero_q;
   logic       ovf_q;

   modport master (
      output a, b, bin,
      input  diff, bout, diff_q, bout_q, zero_q, ovf_q
   );
   modport slave (
      input  a, b, bin,
      output diff, bout, diff_q, bout_q, zero_q, ovf_q
   );
`else
   modport master (
      output a, b, bin,
      input  diff, bout, diff_q, bout_q
   );
   modport slave (
      input  a, b, bin,
      output diff, bout, diff_q, bout_q
   );
`endif
endinterface

// File: rtl/fsc_4bit.sv
// 4-bit ripple-borrow subtractor slice with combinational and registered outputs.
// Optional registered zero/overflow flags under FSC4_FLAGS_EN.
module fsc_4bit (
   input logic       clk,
   input logic       rst,
   fsc_4bit_if.slave bus
);

   logic [4:0] br;
   logic [3:0] diff_c;
   logic [3:0] diff_d, diff_q;
   logic       bout_d, bout_q;

   // Bit-level borrow ripple; kept in one block so the chain stays purely combinational.
   always_comb begin
      br     = '0;
      diff_c = '0;
      br[0]  = bus.bin;
      for (int i = 0; i < 4; i++) begin
         diff_c[i] = bus.a[i] ^ bus.b[i] ^ br[i];
         br[i+1]   = (~bus.a[i] & bus.b[i]) | (~(bus.a[i] ^ bus.b[i]) & br[i]);
      end
   end

   always_comb begin
      diff_d = diff_c;
      bout_d = br[4];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         diff_q <= 4'h0;
         bout_q <= 1'b0;
      end else begin
         diff_q <= diff_d;
         bout_q <= bout_d;
      end
   end

   assign bus.diff   = diff_c;
   assign bus.bout   = br[4];
   assign bus.diff_q = diff_q;
   assign bus.bout_q = bout_q;

`ifdef FSC4_FLAGS_EN
   logic zero_d, zero_q;
   logic ovf_d, ovf_q;

   always_comb begin
      zero_d = (diff_c == 4'h0);
      ovf_d  = (bus.a[3] != bus.b[3]) & (diff_c[3] != bus.a[3]);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         zero_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         zero_q <= zero_d;
         ovf_q  <= ovf_d;
      end
   end

   assign bus.zero_q = zero_q;
   assign bus.ovf_q  = ovf_q;
`endif

endmodule

// File: tb/tb_fsc_4bit.sv
// Randomized and directed bench for fsc_4bit against an arithmetic reference model,
// including a four-slice 16-bit cascade.
module tb_fsc_4bit;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   fsc_4bit_if dut_if ();
   fsc_4bit u_dut (.clk(clk), .rst(rst), .bus(dut_if));

   fsc_4bit_if c0 ();
   fsc_4bit_if c1 ();
   fsc_4bit_if c2 ();
   fsc_4bit_if c3 ();
   logic [15:0] c_a = '0;
   logic [15:0] c_b = '0;
   logic        c_bin = 1'b0;

   assign c0.a = c_a[3:0];
   assign c1.a = c_a[7:4];
   assign c2.a = c_a[11:8];
   assign c3.a = c_a[15:12];
   assign c0.b = c_b[3:0];
   assign c1.b = c_b[7:4];
   assign c2.b = c_b[11:8];
   assign c3.b = c_b[15:12];
   assign c0.bin = c_bin;
   assign c1.bin = c0.bout;
   assign c2.bin = c1.bout;
   assign c3.bin = c2.bout;

   fsc_4bit u_c0 (.clk(clk), .rst(rst), .bus(c0));
   fsc_4bit u_c1 (.clk(clk), .rst(rst), .bus(c1));
   fsc_4bit u_c2 (.clk(clk), .rst(rst), .bus(c2));
   fsc_4bit u_c3 (.clk(clk), .rst(rst), .bus(c3));

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: 5-bit two's-complement wrap of the integer difference.
   function automatic logic [4:0] ref_sub(input int a, input int b, input int bin);
      int r;
      r = a - b - bin;
      return r[4:0];
   endfunction

   // Drive one vector, check combinational outputs, then registered outputs after the edge.
   task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic bin);
      logic [4:0] e;
      e = ref_sub(int'(a), int'(b), int'(bin));
      dut_if.a   = a;
      dut_if.b   = b;
      dut_if.bin = bin;
      #1;
      check_eq("comb_diff", 32'(dut_if.diff), 32'(e[3:0]));
      check_eq("comb_bout", 32'(dut_if.bout), 32'(e[4]));
      @(posedge clk);
      #1;
      check_eq("reg_diff", 32'(dut_if.diff_q), 32'(e[3:0]));
      check_eq("reg_bout", 32'(dut_if.bout_q), 32'(e[4]));
`ifdef FSC4_FLAGS_EN
      check_eq("zero_q", 32'(dut_if.zero_q), 32'(e[3:0] == 4'h0));
      check_eq("ovf_q", 32'(dut_if.ovf_q), 32'((a[3] != b[3]) && (e[3] != a[3])));
`endif
   endtask

   task automatic cascade(input int a, input int b, input int bin);
      int r;
      logic [16:0] e;
      r = a - b - bin;
      e = r[16:0];
      c_a   = 16'(a);
      c_b   = 16'(b);
      c_bin = bin[0];
      #1;
      check_eq("cascade", 32'({c3.bout, c3.diff, c2.diff, c1.diff, c0.diff}), 32'(e));
   endtask

   initial begin
      dut_if.a   = 4'h0;
      dut_if.b   = 4'h1;
      dut_if.bin = 1'b0;

      // Held in reset through an edge despite a nonzero difference on the inputs.
      @(posedge clk);
      #1;
      check_eq("rst_diff_q", 32'(dut_if.diff_q), 32'h0);
      check_eq("rst_bout_q", 32'(dut_if.bout_q), 32'h0);
      check_eq("rst_comb_diff", 32'(dut_if.diff), 32'hF);
      @(negedge clk);
      rst = 1'b1;

      apply(4'hA, 4'h5, 1'b0);
      apply(4'h0, 4'h1, 1'b0);
      apply(4'h0, 4'h0, 1'b1);
      apply(4'h1, 4'h2, 1'b1);
      apply(4'h7, 4'h7, 1'b0);
      apply(4'hF, 4'hF, 1'b1);
      apply(4'hF, 4'h0, 1'b0);
      apply(4'h7, 4'hF, 1'b0);
      apply(4'h3, 4'h3, 1'b0);

      for (int i = 0; i < 512; i++) begin
         apply(4'(i >> 5), 4'(i >> 1), i[0]);
      end
      for (int i = 0; i < 200; i++) begin
         apply(4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)));
      end

      // Asynchronous reset between edges.
      apply(4'hA, 4'h5, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      check_eq("async_diff_q", 32'(dut_if.diff_q), 32'h0);
      check_eq("async_bout_q", 32'(dut_if.bout_q), 32'h0);
      check_eq("async_comb", 32'(dut_if.diff), 32'h5);
      dut_if.a = 4'h0;
      dut_if.b = 4'h1;
      #1;
      check_eq("rst_comb_track", 32'({dut_if.bout, dut_if.diff}), 32'h1F);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         check_eq("hold_diff_q", 32'(dut_if.diff_q), 32'h0);
         check_eq("hold_bout_q", 32'(dut_if.bout_q), 32'h0);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_eq("release_pre", 32'({dut_if.bout_q, dut_if.diff_q}), 32'h0);
      @(posedge clk);
      #1;
      check_eq("release_diff_q", 32'(dut_if.diff_q), 32'hF);
      check_eq("release_bout_q", 32'(dut_if.bout_q), 32'h1);

      cascade(10, 5, 0);
      cascade(12345, 54321, 0);
      cascade(1, 2, 1);
      cascade(0, 0, 1);
      cascade(2357, 9832, 0);
      cascade(65535, 65535, 1);
      for (int i = 0; i < 50; i++) begin
         cascade(int'($urandom_range(65535)), int'($urandom_range(65535)),
                 int'($urandom_range(1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
